// File: rtl/conv_pkg.sv
// conv_pkg: shared FSM encoding and packed-lane slice helper for the convolution engine
package conv_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, OUT} state_t;
  function automatic logic [63:0] lane_slice(input logic [1023:0] vec, input int i, input int w);
    logic [1023:0] t;
    t = vec >> (i * w);
    return t[63:0] & ((64'd1 << w) - 64'd1);
  endfunction
endpackage

// File: rtl/conv_mac_lane.sv
// conv_mac_lane: signed multiply-accumulate with clear, enable and zero-mask
module conv_mac_lane
  import conv_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic                     mask,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc
);
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0] term;
  always_comb begin
    prod = a * b;
    term = mask ? '0 : ACC_W'(prod);
  end
  always_ff @(posedge clk) begin
    if (rst) acc <= '0;
    else if (en) acc <= clr ? term : acc + term;
  end
endmodule

// File: rtl/conv_stream_engine.sv
// conv_stream_engine: streaming 2-D convolution, LANES kernels per output word
module conv_stream_engine
  import conv_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int LANES  = 4,
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [DIM_W-1:0]          cfg_h,
  input  logic [DIM_W-1:0]          cfg_w,
  input  logic [DIM_W-1:0]          cfg_c,
  input  logic [DIM_W-1:0]          cfg_k,
  input  logic [DIM_W-1:0]          cfg_s,
  input  logic [DIM_W-1:0]          cfg_p,
  input  logic [DIM_W-1:0]          cfg_kn,
  input  logic                      cfg_relu,
  output logic [ADDR_W-1:0]         t_addr,
  input  logic [DATA_W-1:0]         t_data,
  output logic [ADDR_W-1:0]         w_addr,
  input  logic [LANES*DATA_W-1:0]   w_data,
  output logic                      o_valid,
  input  logic                      o_ready,
  output logic [LANES*ACC_W-1:0]    o_data,
  output logic [ADDR_W-1:0]         o_addr,
  output logic [LANES-1:0]          o_lane_mask,
  output logic                      busy,
  output logic                      done,
  output logic                      cfg_err
);
  localparam int GW = DIM_W + 2;
  state_t state;
  logic [DIM_W-1:0] h, w, ch, k, s, p, kn, gn, ci, ky, kx, g;
  logic [GW-1:0] oh, ow, oy, ox;
  logic relu, fl, v1, v2, in1, in2, f1, f2, inb, err, last_tap, last_word;
  int iy, ix, ta, wa, hp, wp;
  logic signed [ACC_W-1:0] acc [LANES];
  always_comb begin
    iy = int'(oy) * int'(s) + int'(ky) - int'(p);
    ix = int'(ox) * int'(s) + int'(kx) - int'(p);
    inb = iy >= 0 && iy < int'(h) && ix >= 0 && ix < int'(w);
    ta = (int'(ci) * int'(h) + iy) * int'(w) + ix;
    wa = ((int'(g) * int'(ch) + int'(ci)) * int'(k) + int'(ky)) * int'(k) + int'(kx);
    hp = int'(cfg_h) + 2 * int'(cfg_p);
    wp = int'(cfg_w) + 2 * int'(cfg_p);
    err = cfg_k == '0 || cfg_s == '0 || cfg_c == '0 || cfg_kn == '0 || int'(cfg_k) > hp || int'(cfg_k) > wp;
    last_tap = ci == ch - 1'b1 && ky == k - 1'b1 && kx == k - 1'b1;
    last_word = g == gn - 1'b1 && oy == oh - 1'b1 && ox == ow - 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      {h, w, ch, k, s, p, kn, gn, ci, ky, kx, g} <= '0;
      {oh, ow, oy, ox} <= '0;
      {relu, fl, v1, v2, in1, in2, f1, f2} <= '0;
      {busy, done, cfg_err, o_valid} <= '0;
      {t_addr, w_addr, o_addr} <= '0;
    end else begin
      done <= 1'b0;
      cfg_err <= 1'b0;
      // tap flags travel alongside the registered address and the 1-cycle memory read
      v1 <= state == RUN;
      in1 <= inb;
      f1 <= ci == '0 && ky == '0 && kx == '0;
      v2 <= v1;
      in2 <= in1;
      f2 <= f1;
      case (state)
        IDLE: begin
          if (busy) busy <= 1'b0;
          else if (start && err) cfg_err <= 1'b1;
          else if (start) begin
            {h, w, ch, k, s, p, kn, relu} <= {cfg_h, cfg_w, cfg_c, cfg_k, cfg_s, cfg_p, cfg_kn, cfg_relu};
            oh <= GW'((hp - int'(cfg_k)) / int'(cfg_s) + 1);
            ow <= GW'((wp - int'(cfg_k)) / int'(cfg_s) + 1);
            gn <= DIM_W'((int'(cfg_kn) + LANES - 1) / LANES);
            {ci, ky, kx, g} <= '0;
            {oy, ox} <= '0;
            o_addr <= '0;
            busy <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          t_addr <= inb ? ADDR_W'(ta) : '0;
          w_addr <= ADDR_W'(wa);
          kx <= kx == k - 1'b1 ? '0 : kx + 1'b1;
          if (kx == k - 1'b1) ky <= ky == k - 1'b1 ? '0 : ky + 1'b1;
          if (kx == k - 1'b1 && ky == k - 1'b1) ci <= ci == ch - 1'b1 ? '0 : ci + 1'b1;
          if (last_tap) begin
            fl <= 1'b0;
            state <= FLUSH;
          end
        end
        FLUSH: begin
          fl <= 1'b1;
          if (fl) begin
            o_valid <= 1'b1;
            state <= OUT;
          end
        end
        OUT: begin
          if (o_ready && last_word) begin
            o_valid <= 1'b0;
            done <= 1'b1;
            state <= IDLE;
          end else if (o_ready) begin
            o_valid <= 1'b0;
            o_addr <= o_addr + 1'b1;
            ox <= ox == ow - 1'b1 ? '0 : ox + 1'b1;
            if (ox == ow - 1'b1) oy <= oy == oh - 1'b1 ? '0 : oy + 1'b1;
            if (ox == ow - 1'b1 && oy == oh - 1'b1) g <= g + 1'b1;
            state <= RUN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    conv_mac_lane #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
      .clk(clk),
      .rst(rst),
      .clr(f2),
      .en(v2),
      .mask(!in2),
      .a(t_data),
      .b(DATA_W'(lane_slice(1024'(w_data), i, DATA_W))),
      .acc(acc[i])
    );
    assign o_lane_mask[i] = int'(g) * LANES + i < int'(kn);
    assign o_data[i*ACC_W +: ACC_W] = (!o_lane_mask[i] || (relu && acc[i][ACC_W-1])) ? '0 : acc[i];
  end
endmodule

// File: doc/conv_stream_engine.md
CONV_STREAM_ENGINE -- requirements
Module: conv_stream_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 8, signed tensor/weight element width.
REQ-002 SHALL have parameter ACC_W, default 32, signed accumulator and result width.
REQ-003 SHALL have parameter LANES, default 4, number of kernels computed in parallel.
REQ-004 SHALL have parameter ADDR_W, default 16, memory address width.
REQ-005 SHALL have parameter DIM_W, default 8, width of every geometry field.
REQ-006 SHALL have the ports below; one clock; reset is synchronous and active-high:
  clk  in  1  clock, all logic on rising edge
  rst  in  1  synchronous active-high reset
  start  in  1  single-cycle pulse, latches configuration
  cfg_h, cfg_w  in  DIM_W each  input tensor height, width
  cfg_c  in  DIM_W  channels
  cfg_k  in  DIM_W  square kernel size
  cfg_s  in  DIM_W  stride
  cfg_p  in  DIM_W  zero padding per side
  cfg_kn  in  DIM_W  kernel count
  cfg_relu  in  1  clamp negative results to 0
  t_addr  out  ADDR_W  tensor read address
  t_data  in  DATA_W  tensor read data, 1-cycle latency
  w_addr  out  ADDR_W  weight word address
  w_data  in  LANES*DATA_W  weight word, lane i in bits [i*DATA_W +: DATA_W], 1-cycle latency
  o_valid  out  1  result word valid
  o_ready  in  1  downstream accepts
  o_data  out  LANES*ACC_W  lane results
  o_addr  out  ADDR_W  output word index
  o_lane_mask  out  LANES  lanes holding real kernels
  busy  out  1  job active
  done  out  1  single-cycle pulse after last word accepted
  cfg_err  out  1  single-cycle pulse on rejected configuration

Function
REQ-007 SHALL define OH=(H+2P-K)/S+1, OW=(W+2P-K)/S+1, G=ceil(KN/LANES).
REQ-008 SHALL, on start while IDLE, latch all cfg_* inputs and ignore them until the next job.
REQ-009 SHALL ignore start while busy=1.
REQ-010 SHALL pulse cfg_err, and stay IDLE, when K=0, S=0, C=0, KN=0, or K>H+2P or K>W+2P.
REQ-011 SHALL use FSM IDLE -> RUN (issue taps) -> FLUSH (2 pipeline cycles) -> OUT (hold o_valid) -> RUN for the next word, or -> IDLE with done after the last word.
REQ-012 SHALL order output words g outermost, then oy, then ox; o_addr=(g*OH+oy)*OW+ox.
REQ-013 SHALL iterate taps c outermost, then ky, then kx, issuing one tap per cycle, C*K*K cycles per word.
REQ-014 SHALL form iy=oy*S+ky-P and ix=ox*S+kx-P; t_addr=(c*H+iy)*W+ix; w_addr=((g*C+c)*K+ky)*K+kx.
REQ-015 SHALL treat a tap with iy or ix outside [0,H-1]/[0,W-1] as tensor value 0, with the MAC masked by a flag delayed in step with the read latency.
REQ-016 SHALL compute each lane as a signed DATA_W x DATA_W product, sign-extended, accumulated in ACC_W with two's-complement wrap and no saturation.
REQ-017 SHALL clear the accumulators on the first tap of each word.
REQ-018 SHALL apply ReLU per lane at OUT when cfg_relu=1.
REQ-019 SHALL set o_lane_mask bit i = (g*LANES+i < KN) and force masked lanes of o_data to 0.
REQ-020 SHALL hold o_valid, o_data, o_addr and o_lane_mask stable until o_valid&&o_ready, with o_valid never dropping before acceptance.
REQ-021 SHALL, when o_ready=1 on the first OUT cycle, accept in that cycle, giving per-word latency C*K*K+3 cycles from the first issue.
REQ-022 SHALL keep busy=1 from the cycle after start through the cycle done is asserted.

Reset
REQ-023 SHALL, on rst=1, enter IDLE and clear busy, done, cfg_err, o_valid, o_data, o_addr, o_lane_mask, t_addr, w_addr and all counters to 0, including mid-job, with no done pulse.
REQ-024 SHALL give rst priority over start in the same cycle.

Structure
REQ-025 SHALL place the FSM state encoding and the packed-lane slice helper in the shared package conv_pkg; parameters stay module-local.
REQ-026 SHALL instantiate one sub-module, conv_mac_lane, per lane as a signed MAC with clear, enable and mask, plus one top-level address/loop generator.

Verification
REQ-027 H=W=4, C=1, K=3, S=1, P=0, KN=1, all tensor=1, weights=1 -> 4 words, lane0=9, o_lane_mask=0001, done after word 3.
REQ-028 Same job with P=1 -> 16 words; corner word o_addr=0, lane0=4; edge word o_addr=1, lane0=6; centre word o_addr=5, lane0=9.
REQ-029 KN=5, LANES=4 -> G=2; second group o_lane_mask=0001, lanes 1-3 are 0; 2*OH*OW words total.
REQ-030 Weights=-1, tensor=2, K=2, C=2 -> raw -16; with cfg_relu=1 -> 0, with cfg_relu=0 -> -16.
REQ-031 Hold o_ready=0 for 5 cycles on word 0 -> o_data/o_addr stable, no tap issued, no word lost.
REQ-032 Start with S=0 -> cfg_err pulse, busy stays 0; rst asserted mid-job -> all outputs 0 next cycle, no done, a new start runs cleanly.
